// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle RV32 subset control FSM with memory wait timeout and sticky fault
module mc_control_unit #(
  parameter int ENABLE_BRANCH_EXT = 1,
  parameter int ENABLE_JAL        = 1,
  parameter int MEM_TIMEOUT       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        AdrSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ImmSrc,
  output logic [3:0]  ALUctrl,
  output logic        retire,
  output logic        fault,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JAL_PC = 4'd11,
    S_FAULT = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8, ALU_SLTU = 4'd9;

  // Last wait cycle: a miss here means the counter would reach MEM_TIMEOUT
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     cur, nxt;
  logic [7:0] wait_cnt;
  logic       fault_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  logic waiting, wait_expired, br_legal, br_taken;

  assign waiting      = (cur == S_FETCH) || (cur == S_MEMREAD) || (cur == S_MEMWRITE);
  assign wait_expired = !mem_ready && (wait_cnt == WAIT_LAST);

  function automatic logic [3:0] alu_op(input logic is_r, input logic [2:0] f3, input logic f7b5);
    case (f3)
      3'b000:  alu_op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  // funct7 is only meaningful for R-type and for immediate shifts
  function automatic logic alu_legal(input logic is_r, input logic [2:0] f3, input logic [6:0] f7);
    if (is_r)
      alu_legal = (f7 == 7'b0000000) ||
                  ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
    else if (f3 == 3'b001)
      alu_legal = (f7 == 7'b0000000);
    else if (f3 == 3'b101)
      alu_legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
    else
      alu_legal = 1'b1;
  endfunction

  // Branch legality and taken condition from funct3 and the ALU flags
  always_comb begin
    br_legal = 1'b0;
    br_taken = 1'b0;
    case (funct3)
      3'b000: begin br_legal = 1'b1; br_taken = zero;  end
      3'b001: begin br_legal = 1'b1; br_taken = !zero; end
      3'b100: begin br_legal = (ENABLE_BRANCH_EXT != 0); br_taken = lt;   end
      3'b101: begin br_legal = (ENABLE_BRANCH_EXT != 0); br_taken = !lt;  end
      3'b110: begin br_legal = (ENABLE_BRANCH_EXT != 0); br_taken = ltu;  end
      3'b111: begin br_legal = (ENABLE_BRANCH_EXT != 0); br_taken = !ltu; end
      default: begin br_legal = 1'b0; br_taken = 1'b0; end
    endcase
  end

  // Next-state selection
  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:    if (mem_ready) nxt = S_DECODE; else if (wait_expired) nxt = S_FAULT;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECR;
          OP_I:         nxt = S_EXECI;
          OP_BR:        nxt = S_BRANCH;
          OP_JAL:       nxt = (ENABLE_JAL != 0) ? S_JAL : S_FAULT;
          default:      nxt = S_FAULT;
        endcase
      end
      S_MEMADR:   nxt = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) nxt = S_MEMWB; else if (wait_expired) nxt = S_FAULT;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: if (mem_ready) nxt = S_FETCH; else if (wait_expired) nxt = S_FAULT;
      S_EXECR:    nxt = alu_legal(1'b1, funct3, funct7) ? S_ALUWB : S_FAULT;
      S_EXECI:    nxt = alu_legal(1'b0, funct3, funct7) ? S_ALUWB : S_FAULT;
      S_ALUWB:    nxt = S_FETCH;
      S_BRANCH:   nxt = br_legal ? S_FETCH : S_FAULT;
      S_JAL:      nxt = S_JAL_PC;
      S_JAL_PC:   nxt = S_FETCH;
      S_FAULT:    nxt = S_FAULT;
      default:    nxt = S_FAULT;
    endcase
  end

  // State register, per-state wait counter and sticky fault flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= S_FETCH;
      wait_cnt <= 8'd0;
      fault_q  <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur)
        wait_cnt <= 8'd0;
      else if (waiting && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
      if (nxt == S_FAULT)
        fault_q <= 1'b1;
    end
  end

  assign state = cur;
  assign fault = fault_q;

  // Datapath strobes from state and inputs; all forced low while in reset
  always_comb begin
    PCWrite = 1'b0; IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    RegWrite = 1'b0; AdrSrc = 1'b0; retire = 1'b0;
    ALUSrcA = 2'b00; ALUSrcB = 2'b00; ResultSrc = 2'b00; ImmSrc = 3'b000;
    ALUctrl = ALU_ADD;
    if (!rst) begin
      case (cur)
        S_FETCH: begin
          MemRead = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
          IRWrite = mem_ready; PCWrite = mem_ready;
        end
        S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; ImmSrc = 3'b010; end
        S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ImmSrc = opcode[5] ? 3'b001 : 3'b000; end
        S_MEMREAD:  begin AdrSrc = 1'b1; MemRead = 1'b1; end
        S_MEMWB:    begin RegWrite = 1'b1; ResultSrc = 2'b01; retire = 1'b1; end
        S_MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; retire = mem_ready; end
        S_EXECR:    begin ALUSrcA = 2'b10; ALUctrl = alu_op(1'b1, funct3, funct7[5]); end
        S_EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUctrl = alu_op(1'b0, funct3, funct7[5]); end
        S_ALUWB:    begin RegWrite = 1'b1; retire = 1'b1; end
        S_BRANCH: begin
          ALUSrcA = 2'b10; ImmSrc = 3'b010; ALUctrl = ALU_SUB;
          retire = br_legal; PCWrite = br_legal && br_taken;
        end
        S_JAL: begin
          ImmSrc = 3'b011; ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; RegWrite = 1'b1;
        end
        S_JAL_PC: begin
          ImmSrc = 3'b011; ALUSrcA = 2'b01; ALUSrcB = 2'b01; ResultSrc = 2'b10;
          PCWrite = 1'b1; retire = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - scoreboard bench for mc_control_unit
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        mem_ready = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic        PCWrite, IRWrite, MemRead, MemWrite, RegWrite, AdrSrc, retire, fault;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUctrl, state;
  logic [7:0]  strb;

  mc_control_unit #(.ENABLE_BRANCH_EXT(0), .ENABLE_JAL(1), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .zero(zero), .lt(lt), .ltu(ltu),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUctrl(ALUctrl), .retire(retire),
    .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  assign strb = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, AdrSrc, retire, fault};

  localparam logic [7:0] PCW = 8'h80, IRW = 8'h40, MRD = 8'h20, MWR = 8'h10;
  localparam logic [7:0] RGW = 8'h08, ADR = 8'h04, RET = 8'h02, FLT = 8'h01;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

  typedef struct {
    logic       mr;
    logic [3:0] st;
    logic [7:0] sb;
    logic [3:0] al;
  } row_t;

  row_t exp_q[$];
  row_t r;
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    mk = {f7, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction

  task automatic add_row(input logic mr, input logic [3:0] st, input logic [7:0] sb, input logic [3:0] al);
    row_t e;
    e.mr = mr; e.st = st; e.sb = sb; e.al = al;
    exp_q.push_back(e);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (state !== 4'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
    n_checks++;
    if (strb !== 8'h00) $display("FAIL reset_strobes: got %h want 00", strb); else n_pass++;
    n_checks++;
    if (ALUctrl !== 4'd0) $display("FAIL reset_aluctrl: got %h want 0", ALUctrl); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_lw();
    instr = mk(7'd0, 3'b010, OP_LW);
    add_row(0, 0, MRD, 0); add_row(0, 0, MRD, 0); add_row(1, 0, MRD | IRW | PCW, 0);
    add_row(0, 1, 0, 0); add_row(0, 2, 0, 0);
    add_row(0, 3, MRD | ADR, 0); add_row(0, 3, MRD | ADR, 0); add_row(1, 3, MRD | ADR, 0);
    add_row(0, 4, RGW | RET, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      r = exp_q.pop_front(); mem_ready = r.mr; @(negedge clk); n_checks++;
      if ({state, strb, ALUctrl} !== {r.st, r.sb, r.al})
        $display("FAIL lw row %0d: got st=%0d strb=%h alu=%h want st=%0d strb=%h alu=%h", i, state, strb, ALUctrl, r.st, r.sb, r.al);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sub();
    instr = mk(7'b0100000, 3'b000, OP_R);
    add_row(1, 0, MRD | IRW | PCW, 0); add_row(0, 1, 0, 0);
    add_row(0, 6, 0, 4'd1); add_row(0, 8, RGW | RET, 0);
    add_row(0, 0, MRD, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      r = exp_q.pop_front(); mem_ready = r.mr; @(negedge clk); n_checks++;
      if ({state, strb, ALUctrl} !== {r.st, r.sb, r.al})
        $display("FAIL sub row %0d: got st=%0d strb=%h alu=%h want st=%0d strb=%h alu=%h", i, state, strb, ALUctrl, r.st, r.sb, r.al);
      else n_pass++;
      @(posedge clk); #1;
    end
    pulse_reset();
  endtask

  task automatic test_alu_ops();
    logic [31:0] ins [4];
    logic [3:0]  st  [4];
    logic [3:0]  al  [4];
    ins[0] = mk(7'd0, 3'b100, OP_R);        st[0] = 6; al[0] = 4'd4;
    ins[1] = mk(7'd0, 3'b011, OP_R);        st[1] = 6; al[1] = 4'd9;
    ins[2] = mk(7'b0100000, 3'b101, OP_I);  st[2] = 7; al[2] = 4'd8;
    ins[3] = mk(7'b0100000, 3'b000, OP_I);  st[3] = 7; al[3] = 4'd0;
    for (int k = 0; k < 4; k++) begin
      instr = ins[k];
      add_row(1, 0, MRD | IRW | PCW, 0); add_row(0, 1, 0, 0);
      add_row(0, st[k], 0, al[k]); add_row(0, 8, RGW | RET, 0);
      for (int i = 0; exp_q.size() > 0; i++) begin
        r = exp_q.pop_front(); mem_ready = r.mr; @(negedge clk); n_checks++;
        if ({state, strb, ALUctrl} !== {r.st, r.sb, r.al})
          $display("FAIL alu op %0d row %0d: got st=%0d strb=%h alu=%h want st=%0d strb=%h alu=%h", k, i, state, strb, ALUctrl, r.st, r.sb, r.al);
        else n_pass++;
        @(posedge clk); #1;
      end
    end
    instr = mk(7'b0000001, 3'b000, OP_R);
    add_row(1, 0, MRD | IRW | PCW, 0); add_row(0, 1, 0, 0);
    add_row(0, 6, 0, 0); add_row(0, 15, FLT, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      r = exp_q.pop_front(); mem_ready = r.mr; @(negedge clk); n_checks++;
      if ({state, strb, ALUctrl} !== {r.st, r.sb, r.al})
        $display("FAIL bad funct7 row %0d: got st=%0d strb=%h alu=%h want st=%0d strb=%h alu=%h", i, state, strb, ALUctrl, r.st, r.sb, r.al);
      else n_pass++;
      @(posedge clk); #1;
    end
    pulse_reset();
  endtask

  task automatic test_sw();
    instr = mk(7'd0, 3'b010, OP_SW);
    add_row(1, 0, MRD | IRW | PCW, 0); add_row(0, 1, 0, 0); add_row(0, 2, 0, 0);
    add_row(0, 5, MWR | ADR, 0); add_row(1, 5, MWR | ADR | RET, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      r = exp_q.pop_front(); mem_ready = r.mr; @(negedge clk); n_checks++;
      if ({state, strb, ALUctrl} !== {r.st, r.sb, r.al})
        $display("FAIL sw row %0d: got st=%0d strb=%h alu=%h want st=%0d strb=%h alu=%h", i, state, strb, ALUctrl, r.st, r.sb, r.al);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3  [3];
    logic       z   [3];
    logic [7:0] sb  [3];
    f3[0] = 3'b001; z[0] = 1'b1; sb[0] = RET;
    f3[1] = 3'b001; z[1] = 1'b0; sb[1] = PCW | RET;
    f3[2] = 3'b000; z[2] = 1'b1; sb[2] = PCW | RET;
    for (int k = 0; k < 3; k++) begin
      instr = mk(7'd0, f3[k], OP_BR); zero = z[k];
      add_row(1, 0, MRD | IRW | PCW, 0); add_row(0, 1, 0, 0); add_row(0, 9, sb[k], 4'd1);
      for (int i = 0; exp_q.size() > 0; i++) begin
        r = exp_q.pop_front(); mem_ready = r.mr; @(negedge clk); n_checks++;
        if ({state, strb, ALUctrl} !== {r.st, r.sb, r.al})
          $display("FAIL branch %0d row %0d: got st=%0d strb=%h alu=%h want st=%0d strb=%h alu=%h", k, i, state, strb, ALUctrl, r.st, r.sb, r.al);
        else n_pass++;
        @(posedge clk); #1;
      end
    end
    instr = mk(7'd0, 3'b110, OP_BR); ltu = 1'b1;
    add_row(1, 0, MRD | IRW | PCW, 0); add_row(0, 1, 0, 0); add_row(0, 9, 0, 4'd1);
    add_row(0, 15, FLT, 0); add_row(1, 15, FLT, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      r = exp_q.pop_front(); mem_ready = r.mr; @(negedge clk); n_checks++;
      if ({state, strb, ALUctrl} !== {r.st, r.sb, r.al})
        $display("FAIL bltu disabled row %0d: got st=%0d strb=%h alu=%h want st=%0d strb=%h alu=%h", i, state, strb, ALUctrl, r.st, r.sb, r.al);
      else n_pass++;
      @(posedge clk); #1;
    end
    ltu = 1'b0; zero = 1'b0;
    pulse_reset();
  endtask

  task automatic test_jal();
    instr = mk(7'd0, 3'b000, OP_JAL);
    add_row(1, 0, MRD | IRW | PCW, 0); add_row(0, 1, 0, 0);
    add_row(0, 10, RGW, 0); add_row(0, 11, PCW | RET, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      r = exp_q.pop_front(); mem_ready = r.mr; @(negedge clk); n_checks++;
      if ({state, strb, ALUctrl} !== {r.st, r.sb, r.al})
        $display("FAIL jal row %0d: got st=%0d strb=%h alu=%h want st=%0d strb=%h alu=%h", i, state, strb, ALUctrl, r.st, r.sb, r.al);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    instr = 32'd0;
    add_row(1, 0, MRD | IRW | PCW, 0); add_row(0, 1, 0, 0); add_row(1, 15, FLT, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      r = exp_q.pop_front(); mem_ready = r.mr; @(negedge clk); n_checks++;
      if ({state, strb, ALUctrl} !== {r.st, r.sb, r.al})
        $display("FAIL illegal opcode row %0d: got st=%0d strb=%h alu=%h want st=%0d strb=%h alu=%h", i, state, strb, ALUctrl, r.st, r.sb, r.al);
      else n_pass++;
      @(posedge clk); #1;
    end
    pulse_reset();
  endtask

  task automatic test_timeout();
    instr = mk(7'd0, 3'b000, OP_R);
    for (int k = 0; k < 4; k++) add_row(0, 0, MRD, 0);
    add_row(1, 15, FLT, 0); add_row(1, 15, FLT, 0); add_row(0, 15, FLT, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      r = exp_q.pop_front(); mem_ready = r.mr; @(negedge clk); n_checks++;
      if ({state, strb, ALUctrl} !== {r.st, r.sb, r.al})
        $display("FAIL timeout row %0d: got st=%0d strb=%h alu=%h want st=%0d strb=%h alu=%h", i, state, strb, ALUctrl, r.st, r.sb, r.al);
      else n_pass++;
      @(posedge clk); #1;
    end
    pulse_reset();
    for (int k = 0; k < 3; k++) add_row(0, 0, MRD, 0);
    add_row(1, 0, MRD | IRW | PCW, 0); add_row(0, 1, 0, 0);
    add_row(0, 6, 0, 0); add_row(0, 8, RGW | RET, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      r = exp_q.pop_front(); mem_ready = r.mr; @(negedge clk); n_checks++;
      if ({state, strb, ALUctrl} !== {r.st, r.sb, r.al})
        $display("FAIL last-cycle ready row %0d: got st=%0d strb=%h alu=%h want st=%0d strb=%h alu=%h", i, state, strb, ALUctrl, r.st, r.sb, r.al);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_memwrite_reset();
    instr = mk(7'd0, 3'b010, OP_SW);
    add_row(1, 0, MRD | IRW | PCW, 0); add_row(0, 1, 0, 0); add_row(0, 2, 0, 0);
    add_row(0, 5, MWR | ADR, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      r = exp_q.pop_front(); mem_ready = r.mr; @(negedge clk); n_checks++;
      if ({state, strb, ALUctrl} !== {r.st, r.sb, r.al})
        $display("FAIL sw abort row %0d: got st=%0d strb=%h alu=%h want st=%0d strb=%h alu=%h", i, state, strb, ALUctrl, r.st, r.sb, r.al);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (MemWrite !== 1'b1) $display("FAIL memwrite_held: got %b want 1", MemWrite); else n_pass++;
    rst = 1'b1; #1;
    n_checks++;
    if (MemWrite !== 1'b0) $display("FAIL memwrite_drop_on_rst: got %b want 0", MemWrite); else n_pass++;
    n_checks++;
    if (state !== 4'd0) $display("FAIL state_async_rst: got %0d want 0", state); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({state, MemWrite, fault} !== {4'd0, 1'b0, 1'b0})
      $display("FAIL after_release: got st=%0d mw=%b fault=%b want st=0 mw=0 fault=0", state, MemWrite, fault);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sub();
    test_alu_ops();
    test_sw();
    test_branch();
    test_jal();
    test_illegal();
    test_timeout();
    test_memwrite_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter ENABLE_BRANCH_EXT, default 1; meaning: 1 enables blt/bge/bltu/bgeu, 0 makes them illegal.
REQ-002 Parameter ENABLE_JAL, default 1; meaning: 1 enables jal (opcode 1101111), 0 makes it illegal.
REQ-003 Parameter MEM_TIMEOUT, default 16, range 2..255; meaning: maximum cycles to wait for mem_ready.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 instr  in  32  contents of the external instruction register; decoded only in states after FETCH.
REQ-007 mem_ready  in  1  memory access complete this cycle.
REQ-008 zero / lt / ltu  in  1 each  ALU flags for rs1-rs2: equal, signed less-than, unsigned less-than.
REQ-009 PCWrite, IRWrite, MemRead, MemWrite, RegWrite, AdrSrc  out  1 each  datapath strobes and selects.
REQ-010 ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1.
REQ-011 ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4.
REQ-012 ResultSrc  out  2  00 ALUOut, 01 memory data, 10 ALU result.
REQ-013 ImmSrc  out  3  000 I, 001 S, 010 B, 011 J.
REQ-014 ALUctrl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu.
REQ-015 retire  out  1  one-cycle pulse when an instruction completes.
REQ-016 fault  out  1  sticky; set on illegal instruction or memory timeout.
REQ-017 state  out  4  current FSM state code, for debug.

Function
REQ-018 States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, FAULT 15.
REQ-019 FETCH: MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUctrl=add, and the FSM holds until mem_ready.
REQ-020 On mem_ready in FETCH: IRWrite=1 and PCWrite=1 (PC+4, ResultSrc=10) in the same cycle, then DECODE.
REQ-021 DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=010, ALUctrl=add (branch target into ALUOut).
REQ-022 DECODE dispatch: lw/sw (0000011/0100011) -> MEMADR; R-type (0110011) -> EXECR; I-ALU (0010011) -> EXECI; branch (1100011) -> BRANCH; jal -> JAL; any other opcode -> FAULT.
REQ-023 MEMADR: rs1+imm; ImmSrc is 000 for lw and 001 for sw; lw -> MEMREAD, sw -> MEMWRITE.
REQ-024 MEMREAD and MEMWRITE: AdrSrc=1 with MemRead or MemWrite held until mem_ready; MEMREAD -> MEMWB; MEMWRITE -> FETCH with retire=1.
REQ-025 MEMWB: RegWrite=1, ResultSrc=01, retire=1, then FETCH.
REQ-026 EXECR/EXECI decode from funct3 and funct7[5]: add/sub (sub only when R-type and funct7[5]=1), sll, slt, sltu, xor, srl/sra (funct7[5]), or, and; illegal funct7 -> FAULT; then ALUWB.
REQ-027 ALUWB: RegWrite=1, ResultSrc=00, retire=1, then FETCH.
REQ-028 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUctrl=sub, ResultSrc=00.
REQ-029 Branch taken conditions: beq zero; bne !zero; blt lt; bge !lt; bltu ltu; bgeu !ltu.
REQ-030 If the branch is taken, PCWrite=1; retire=1 either way; then FETCH.
REQ-031 Branch funct3 010/011 are always illegal -> FAULT; funct3 100-111 -> FAULT when ENABLE_BRANCH_EXT=0.
REQ-032 Every funct3 value has a defined outcome, and no output is latched.
REQ-033 JAL: ImmSrc=011, ALUSrcA=01, ALUSrcB=01, ALUctrl=add, PCWrite=1.
REQ-034 JAL link: RegWrite=1 with ResultSrc=10 is not usable, so JAL takes two cycles: first link rd=OldPC+4 (ALUSrcB=10, RegWrite=1), then PC update, with retire on the second cycle.
REQ-035 Wait counter: 8 bits, cleared on state entry, incremented each cycle mem_ready=0 in FETCH, MEMREAD or MEMWRITE.
REQ-036 Timeout: when the counter reaches MEM_TIMEOUT -> FAULT.
REQ-037 mem_ready on the same cycle the counter reaches MEM_TIMEOUT counts as success.
REQ-038 FAULT: all strobes 0, fault=1, and the FSM stays in FAULT until rst.
REQ-039 All strobes are Moore or state+input combinational; no strobe is asserted in a cycle after its state exits.

Reset
REQ-040 rst asserted at any time forces state=FETCH, counter=0 and fault=0 asynchronously.
REQ-041 While rst=1, all strobes, retire and ALUctrl are 0.
REQ-042 An in-flight memory access is abandoned on reset (MemWrite drops immediately).

Verification
REQ-043 lw: opcode 0000011, mem_ready after 2 waits in FETCH and MEMREAD -> state sequence 0,0,0,1,2,3,3,3,4,0; RegWrite in state 4; one retire.
REQ-044 R-type sub, funct7=0100000, funct3=000 -> ALUctrl=0001 in EXECR, RegWrite in ALUWB, 4 cycles total with mem_ready=1.
REQ-045 bne with zero=1 -> PCWrite=0 in BRANCH; with zero=0 -> PCWrite=1; bltu with ltu=1 and ENABLE_BRANCH_EXT=0 -> FAULT.
REQ-046 mem_ready held 0 in FETCH with MEM_TIMEOUT=4 -> FAULT after 4 cycles, fault=1 sticky until rst.
REQ-047 Opcode 0000000 -> FAULT from DECODE; rst pulsed mid-MEMWRITE -> MemWrite=0 immediately and state=0 after release.
